// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared state encoding and demux helper for the bit-serial adder
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One-hot 1x4 demux: routes d to the output selected by sel.
  function automatic logic [3:0] demux_1x4(input logic d, input logic [1:0] sel);
    logic [3:0] y;
    y      = 4'b0000;
    y[sel] = d;
    return y;
  endfunction

endpackage

// File: rtl/fa_using_1x4_demux.sv
// rtl/fa_using_1x4_demux.sv - combinational 1-bit full adder built from two demux half adders
module fa_using_1x4_demux
  import bit_serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic [3:0] h1;
  logic [3:0] h2;
  logic       s1;

  // Each demux decodes a bit pair: outputs 1/2 mean exactly one is set, output 3 means both.
  assign h1    = demux_1x4(1'b1, {a, b});
  assign s1    = h1[1] | h1[2];
  assign h2    = demux_1x4(1'b1, {s1, cin});
  assign sum   = h2[1] | h2[2];
  assign carry = h1[3] | h2[3];

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - bit-serial WIDTH-bit adder, LSB-first through a single full-adder cell
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  fa_using_1x4_demux u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .carry(fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          if (cnt == CNT_LAST) begin
            cout  <= fa_c;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        // Illegal code: drop back to IDLE, leaving sum/cout as they were.
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - scoreboard bench for bit_serial_adder against a/b/cin arithmetic
module tb_bit_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] res;
    int             accept_edge;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   free_at = 0;
  bit   abort_flag = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: an accepted request yields {cout,sum} = a+b+cin, and the adder is
  // unavailable for WIDTH+2 edges after acceptance.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      free_at    = cyc + 1;
      abort_flag = 1;
    end else if (start && cyc >= free_at) begin
      e.res         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.accept_edge = cyc;
      exp_q.push_back(e);
      free_at = cyc + WIDTH + 2;
    end
  end

  int               busy_run = 0;
  bit               done_prev = 0;
  bit               hold_valid = 0;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_width", {31'b0, done_prev}, 32'd0);
      check("done_implies_busy", {31'b0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", {24'b0, sum}, {24'b0, e.res[WIDTH-1:0]});
        check("cout", {31'b0, cout}, {31'b0, e.res[WIDTH]});
        check("done_latency", cyc - e.accept_edge, WIDTH);
      end
      hold_valid = 1;
      held_sum   = sum;
      held_cout  = cout;
    end else if (hold_valid) begin
      if (rst || busy) begin
        hold_valid = 0;
      end else begin
        check("sum_hold", {23'b0, cout, sum}, {23'b0, held_cout, held_sum});
      end
    end
    done_prev = done;
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run > 0 && !abort_flag) check("busy_width", busy_run, WIDTH + 1);
      busy_run   = 0;
      abort_flag = 0;
    end
  end

  task automatic pulse(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_sum", {24'b0, sum}, 32'd0);
    check("reset_cout", {31'b0, cout}, 32'd0);

    pulse(8'h05, 8'h03, 1'b0); repeat (WIDTH + 1) @(negedge clk);
    pulse(8'hFF, 8'h01, 1'b0); repeat (WIDTH + 1) @(negedge clk);
    pulse(8'hFF, 8'hFF, 1'b1); repeat (WIDTH + 1) @(negedge clk);

    // Second request three edges into a run must be ignored.
    pulse(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    // Reset in the middle of a run aborts it.
    pulse(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_sum", {24'b0, sum}, 32'd0);
    check("abort_cout", {31'b0, cout}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    pulse(8'h7F, 8'h01, 1'b0); repeat (WIDTH + 1) @(negedge clk);

    // Held start relaunches every WIDTH+2 cycles; operands change mid-run.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    repeat (14) @(negedge clk);
    a = 8'h03; b = 8'h04;
    repeat (16) @(negedge clk);
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      pulse(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      repeat (WIDTH + $urandom_range(0, 2)) @(negedge clk);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
